// File: rtl/fir_pkg.sv
// Shared width/shift/saturation helpers for the parametrised FIR filter.
// Optional build macro FIR_SAT_EN (used by fir_param) selects output saturation.
package fir_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int prod_w(input int dw, input int cw);
        return dw + cw;
    endfunction

    // Full-precision accumulator: product width plus growth for the tap sum.
    function automatic int acc_w(input int dw, input int cw, input int n_taps);
        return dw + cw + clog2(n_taps);
    endfunction

    // Coefficients are Q1.(CW-1), so the sum is rescaled by CW-1 bits.
    function automatic int shift_amt(input int cw);
        return cw - 1;
    endfunction

    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/fir_tap_mult.sv
// Signed DW x CW tap multiplier with an optional enabled output register.
module fir_tap_mult
    import fir_pkg::*;
#(
    parameter int DW      = 12,
    parameter int CW      = 12,
    parameter int OUT_REG = 0
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              en,
    input  logic signed [DW-1:0]              a,
    input  logic signed [CW-1:0]              b,
    output logic signed [prod_w(DW, CW)-1:0]  p
);

    localparam int PW = prod_w(DW, CW);

    logic signed [PW-1:0] prod;

    assign prod = PW'(a) * PW'(b);

    generate
        if (OUT_REG != 0) begin : g_reg
            // NOTE: registers are written with <= so every flop samples pre-edge values.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    p <= '0;
                end else if (en) begin
                    p <= prod;
                end
            end
        end else begin : g_comb
            logic unused_ok;
            assign unused_ok = ^{CLK, RST_N, en};
            assign p = prod;
        end
    endgenerate

endmodule

// File: rtl/fir_param.sv
// Parametrised direct-form FIR with runtime coefficient load and optional product pipeline.
// Build macro FIR_SAT_EN: clamp the rescaled sum to the DW range instead of wrapping.
module fir_param
    import fir_pkg::*;
#(
    parameter int N_TAPS = 9,
    parameter int DW     = 12,
    parameter int CW     = 12,
    parameter int PIPE   = 0
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic signed [DW-1:0]        DIN,
    input  logic                        VIN,
    input  logic                        H_WE,
    input  logic [clog2(N_TAPS)-1:0]    H_ADDR,
    input  logic signed [CW-1:0]        H_DATA,
    output logic signed [DW-1:0]        DOUT,
    output logic                        VOUT
);

    localparam int AB = clog2(N_TAPS);
    localparam int PW = prod_w(DW, CW);
    localparam int AW = acc_w(DW, CW, N_TAPS);
    localparam int SH = shift_amt(CW);

    logic signed [DW-1:0] x    [N_TAPS];
    logic signed [CW-1:0] h    [N_TAPS];
    logic signed [PW-1:0] prod [N_TAPS];

    logic                 h_we_q;
    logic [AB-1:0]        h_addr_q;
    logic signed [CW-1:0] h_data_q;

    logic                 v0;
    logic                 v_last;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sh;
    logic signed [DW-1:0] y;

    // Writes commit one edge late so a sample accepted on the write edge still sees the old tap.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_we_q   <= 1'b0;
            h_addr_q <= '0;
            h_data_q <= '0;
        end else begin
            h_we_q   <= H_WE;
            h_addr_q <= H_ADDR;
            h_data_q <= H_DATA;
        end
    end

    // NOTE: delay line and coefficient bank are small flop arrays and must clear on reset, so they are reset element by element.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_TAPS; i++) begin
                x[i] <= '0;
                h[i] <= '0;
            end
        end else begin
            if (VIN) begin
                x[0] <= DIN;
                for (int i = 1; i < N_TAPS; i++) x[i] <= x[i-1];
            end
            if (h_we_q && (int'(h_addr_q) < N_TAPS)) begin
                h[h_addr_q] <= h_data_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) v0 <= 1'b0;
        else        v0 <= VIN;
    end

    for (genvar i = 0; i < N_TAPS; i++) begin : g_tap
        fir_tap_mult #(
            .DW      (DW),
            .CW      (CW),
            .OUT_REG (PIPE)
        ) u_mult (
            .CLK   (CLK),
            .RST_N (RST_N),
            .en    (v0),
            .a     (x[i]),
            .b     (h[i]),
            .p     (prod[i])
        );
    end

    generate
        if (PIPE != 0) begin : g_pipe
            logic v1;
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) v1 <= 1'b0;
                else        v1 <= v0;
            end
            assign v_last = v1;
        end else begin : g_nopipe
            assign v_last = v0;
        end
    endgenerate

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        acc = '0;
        for (int i = 0; i < N_TAPS; i++) acc = acc + AW'(prod[i]);
    end

`ifdef FIR_SAT_EN
    localparam logic signed [AW-1:0] SAT_HI = AW'(sat_max(DW));
    localparam logic signed [AW-1:0] SAT_LO = AW'(sat_min(DW));

    always_comb begin
        sh = acc >>> SH;
        y  = DW'(sh);
        if (sh > SAT_HI)      y = DW'(SAT_HI);
        else if (sh < SAT_LO) y = DW'(SAT_LO);
    end
`else
    always_comb begin
        sh = acc >>> SH;
        y  = DW'(sh);
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DOUT <= '0;
            VOUT <= 1'b0;
        end else begin
            VOUT <= v_last;
            if (v_last) DOUT <= y;
        end
    end

endmodule

// File: tb/tb_fir_param.sv
// Directed bench for fir_param: a PIPE=0 and a PIPE=1 instance share one stimulus stream.
module tb_fir_param;

    localparam int N  = 9;
    localparam int DW = 12;
    localparam int CW = 12;

`ifdef FIR_SAT_EN
    localparam int OVF_POS = 2047;
    localparam int OVF_NEG = -2048;
    localparam int UPD_A   = 2047;
    localparam int UPD_B   = 2047;
`else
    localparam int OVF_POS = 2030;
    localparam int OVF_NEG = -2039;
    localparam int UPD_A   = 404;
    localparam int UPD_B   = -96;
`endif

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic signed [DW-1:0] DIN;
    logic                 VIN;
    logic                 H_WE;
    logic [3:0]           H_ADDR;
    logic signed [CW-1:0] H_DATA;
    logic signed [DW-1:0] dout0, dout1;
    logic                 vout0, vout1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    fir_param #(.N_TAPS(N), .DW(DW), .CW(CW), .PIPE(0)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .VIN(VIN), .H_WE(H_WE),
        .H_ADDR(H_ADDR), .H_DATA(H_DATA), .DOUT(dout0), .VOUT(vout0)
    );

    fir_param #(.N_TAPS(N), .DW(DW), .CW(CW), .PIPE(1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .VIN(VIN), .H_WE(H_WE),
        .H_ADDR(H_ADDR), .H_DATA(H_DATA), .DOUT(dout1), .VOUT(vout1)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later, return inputs to idle.
    task automatic tick(input logic vin, input logic signed [DW-1:0] din);
        VIN = vin;
        DIN = din;
        @(posedge CLK);
        #1;
        VIN  = 1'b0;
        DIN  = '0;
        H_WE = 1'b0;
    endtask

    task automatic load_all(input logic signed [CW-1:0] c);
        for (int i = 0; i < N; i++) begin
            H_WE   = 1'b1;
            H_ADDR = 4'(i);
            H_DATA = c;
            tick(1'b0, '0);
        end
    endtask

    initial begin
        RST_N  = 1'b0;
        VIN    = 1'b0;
        DIN    = '0;
        H_WE   = 1'b0;
        H_ADDR = '0;
        H_DATA = '0;
        #2;
        check("rst_dout0", dout0, 0);
        check("rst_vout0", vout0, 0);
        check("rst_dout1", dout1, 0);
        check("rst_vout1", vout1, 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Impulse, back-to-back samples: nine outputs of 1023 then 0.
        load_all(12'sd1024);
        for (int i = 0; i < 12; i++) begin
            tick(i < 10, (i == 0) ? 12'sd2047 : 12'sd0);
            if (i == 1) check("imp_v1_early", vout1, 0);
            if (i >= 1 && i <= 10) begin
                check("imp_vout0", vout0, 1);
                check("imp_dout0", dout0, (i - 1 < 9) ? 1023 : 0);
            end
            if (i == 11) check("imp_vout0_end", vout0, 0);
            if (i >= 2) begin
                check("imp_vout1", vout1, 1);
                check("imp_dout1", dout1, (i - 2 < 9) ? 1023 : 0);
            end
        end

        // Impulse with three idle cycles after every sample.
        for (int s = 0; s < 10; s++) begin
            int e;
            e = (s < 9) ? 1023 : 0;
            tick(1'b1, (s == 0) ? 12'sd2047 : 12'sd0);
            tick(1'b0, '0);
            check("gap_vout0_a", vout0, 1);
            check("gap_dout0_a", dout0, e);
            check("gap_vout1_a", vout1, 0);
            tick(1'b0, '0);
            check("gap_vout0_b", vout0, 0);
            check("gap_dout0_b", dout0, e);
            check("gap_vout1_b", vout1, 1);
            check("gap_dout1_b", dout1, e);
            tick(1'b0, '0);
            check("gap_vout0_c", vout0, 0);
            check("gap_vout1_c", vout1, 0);
            check("gap_dout0_c", dout0, e);
            check("gap_dout1_c", dout1, e);
        end

        // Step response: 226 on the first sample, settling at 2042.
        load_all(12'sd227);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 12'sd2047);
            if (i == 1) check("step_first", dout0, 226);
            if (i >= 9) check("step_dout0", dout0, 2042);
            if (i >= 10) check("step_dout1", dout1, 2042);
        end

        // Overflow, positive then negative full-scale input.
        load_all(12'sd2047);
        for (int i = 0; i < 12; i++) tick(1'b1, 12'sd2047);
        check("ovf_pos0", dout0, OVF_POS);
        check("ovf_pos1", dout1, OVF_POS);
        for (int i = 0; i < 12; i++) tick(1'b1, 12'sh800);
        check("ovf_neg0", dout0, OVF_NEG);
        check("ovf_neg1", dout1, OVF_NEG);

        // Coefficient write on the same edge as a sample.
        load_all(12'sd1024);
        for (int i = 0; i < 10; i++) tick(1'b1, 12'sd1000);
        H_WE   = 1'b1;
        H_ADDR = 4'd0;
        H_DATA = 12'sd0;
        tick(1'b1, 12'sd1000);
        tick(1'b0, '0);
        check("upd_same0", dout0, UPD_A);
        tick(1'b0, '0);
        check("upd_same1", dout1, UPD_A);
        tick(1'b1, 12'sd1000);
        tick(1'b0, '0);
        check("upd_next0", dout0, UPD_B);
        tick(1'b0, '0);
        check("upd_next1", dout1, UPD_B);

        // Out-of-range tap index is ignored.
        H_WE   = 1'b1;
        H_ADDR = 4'd9;
        H_DATA = 12'sh7FF;
        tick(1'b0, '0);
        tick(1'b1, 12'sd1000);
        tick(1'b0, '0);
        check("addr9_dout0", dout0, UPD_B);
        tick(1'b0, '0);
        check("addr9_dout1", dout1, UPD_B);

        // Reset while a sample is in flight, then a fresh history.
        tick(1'b1, 12'sd1000);
        RST_N = 1'b0;
        #1;
        check("mrst_vout0", vout0, 0);
        check("mrst_dout0", dout0, 0);
        check("mrst_vout1", vout1, 0);
        check("mrst_dout1", dout1, 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        check("mrst_hold_vout0", vout0, 0);
        load_all(12'sd1024);
        tick(1'b1, 12'sd1000);
        tick(1'b0, '0);
        check("post_vout0", vout0, 1);
        check("post_dout0", dout0, 500);
        tick(1'b0, '0);
        check("post_vout1", vout1, 1);
        check("post_dout1", dout1, 500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_param.md
Name: fir_param

Overview:
- Parametrised direct-form FIR filter; generalises the fixed 9-tap, 12-bit filter to N_TAPS taps with independent data and coefficient widths.
- Adds a runtime coefficient-load port in place of fixed per-tap inputs, and an optional multiplier/adder pipeline stage.
- Sits between the sample source (DIN/VIN stream) and the downstream consumer (DOUT/VOUT stream).
- Drop-in for the existing FIR slot at N_TAPS=9, DW=12, CW=12, PIPE=0.

Parameters:
- N_TAPS, 9: number of taps (filter order + 1); 2..32.
- DW, 12: DIN/DOUT width, signed two's complement.
- CW, 12: coefficient width, signed, Q1.(CW-1).
- PIPE, 0: 0 or 1; 1 inserts a register between the product stage and the adder tree.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- DIN  in  DW  input sample, signed.
- VIN  in  1  DIN valid; a sample is accepted on each rising edge with VIN=1.
- H_WE  in  1  coefficient write enable.
- H_ADDR  in  clog2(N_TAPS)  tap index to write.
- H_DATA  in  CW  coefficient value, signed.
- DOUT  out  DW  filtered output, signed.
- VOUT  out  1  DOUT valid, one-cycle pulse per accepted sample.

Behaviour:
- Reset, asynchronous on RST_N low:
  - delay line x[0..N_TAPS-1] = 0, coefficients h[] = 0, pipeline registers = 0.
  - DOUT = 0, VOUT = 0.
- Acceptance: on an edge with VIN=1, x[0] <= DIN and x[i] <= x[i-1]. With VIN=0 the delay line holds; no bubbles enter the history.
- Arithmetic:
  - acc = sum over i of h[i]*x[i], computed at full precision in DW+CW+clog2(N_TAPS) bits.
  - DOUT = acc arithmetically shifted right by CW-1 (floor), then truncated to DW bits (two's-complement wrap).
- Latency:
  - A sample accepted at edge k gives DOUT/VOUT=1 after edge k+1+PIPE.
  - Back-to-back VIN=1 gives back-to-back VOUT=1; throughput is one sample per clock.
- Outputs between samples: VOUT=1 for exactly one cycle per accepted sample. DOUT holds its last value while VOUT=0.
- Coefficient write:
  - On an edge with H_WE=1 and H_ADDR<N_TAPS, h[H_ADDR] <= H_DATA.
  - A write with H_ADDR>=N_TAPS is ignored.
- Simultaneous VIN=1 and H_WE=1 on the same edge: that sample's output uses the old coefficient; the new value applies from the next accepted sample on.
- With PIPE=1, a coefficient write does not alter products already registered in the pipeline.
- Reset mid-operation: in-flight results are discarded and VOUT=0. After release, the first output uses a zero history plus the new sample.
- No backpressure: the consumer must accept every VOUT pulse.

Optional Feature:
- Macro FIR_SAT_EN.
- Defined: after the shift, values above 2^(DW-1)-1 clamp to 2^(DW-1)-1, and values below -2^(DW-1) clamp to -2^(DW-1).
- Undefined: plain two's-complement wrap on truncation.
- Latency is identical in both builds.

Decomposition:
- Package fir_pkg holds:
  - function clog2;
  - localparam-derived width helpers (product width, accumulator width);
  - shift amount CW-1;
  - saturation bound constants.
- One sub-module, fir_tap_mult: signed DW x CW multiplier with optional output register, instantiated per tap under PIPE.
- Adder tree and delay line stay in the top module.

Test Plan (N_TAPS=9, DW=12, CW=12, PIPE=0 unless stated):
- Impulse: load h[i]=1024 for all i; feed x=2047 then 8 zeros, VIN=1 each cycle -> 9 consecutive VOUT pulses, each DOUT=1023; 10th output 0.
- Step: all h=227; 9+ samples of 2047 -> DOUT ramps up and settles at 2042 once the delay line is full.
- Overflow: all h=2047, x=2047 held -> steady DOUT=2047 with FIR_SAT_EN, 2030 without. With x=-2048 held -> -2048 with FIR_SAT_EN, -2039 without.
- VIN gaps: impulse case with 3 idle cycles between samples -> same DOUT sequence, VOUT only 1 cycle after each accepted sample, DOUT stable during gaps.
- Coefficient update: h=1024 for all taps, stream x=1000 constant; write h[0]=0 on the same edge as a VIN=1 sample. That output still equals 1000*9*1024>>11=4500, wrapped or saturated per build; the next output reflects h[0]=0. A write to H_ADDR=9 changes nothing.
- Reset mid-stream and PIPE=1: assert RST_N low for 1 cycle while samples are in flight -> VOUT=0, DOUT=0 immediately. With PIPE=1, the impulse case appears 2 edges after acceptance.
